ex_mem_pipe: RTL and testbench

Parametrised, elastic successor of the EX->MEM pipeline register. It carries a control field and a packed data payload between the execute and memory stages over a valid/ready handshake, and can be configured as 1..N chained register stages. Each stage is a skid buffer, so stalls propagate without combinational ready paths. It adds a synchronous flush that squashes in-flight instructions, used for branch mispredict and exception redirect, and control gating so that a bubble never carries live write enables.

---
 rtl/ex_mem_pkg.sv | 55 +++++
 rtl/pipe_skid_stage.sv | 70 +++++++
 rtl/ex_mem_pipe.sv | 80 ++++++++
 tb/tb_ex_mem_pipe.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// EX->MEM pipeline package: control bit indices, payload field layout and
// pack/unpack helpers shared by the pipe and its users.
package ex_mem_pkg;

  localparam int CTRL_W        = 4;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_BRANCH   = 3;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // Payload layout, LSB first: Zero, WriteReg, PCplus4, PCBranch, WriteData, ALUOut
  localparam int ZERO_LSB  = 0;
  localparam int WREG_LSB  = 1;
  localparam int PC4_LSB   = WREG_LSB + REG_W;
  localparam int PCB_LSB   = PC4_LSB + DATA_W;
  localparam int WDATA_LSB = PCB_LSB + DATA_W;
  localparam int ALU_LSB   = WDATA_LSB + DATA_W;
  localparam int PAYLOAD_W = ALU_LSB + DATA_W;

  typedef struct packed {
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] pc_branch;
    logic [DATA_W-1:0] pc_plus4;
    logic [REG_W-1:0]  write_reg;
    logic              zero;
  } ex_mem_payload_t;

  function automatic logic [PAYLOAD_W-1:0] pack_payload(input ex_mem_payload_t p);
    logic [PAYLOAD_W-1:0] w;
    w = '0;
    w[ALU_LSB   +: DATA_W] = p.alu_out;
    w[WDATA_LSB +: DATA_W] = p.write_data;
    w[PCB_LSB   +: DATA_W] = p.pc_branch;
    w[PC4_LSB   +: DATA_W] = p.pc_plus4;
    w[WREG_LSB  +: REG_W]  = p.write_reg;
    w[ZERO_LSB]            = p.zero;
    return w;
  endfunction

  function automatic ex_mem_payload_t unpack_payload(input logic [PAYLOAD_W-1:0] w);
    ex_mem_payload_t p;
    p.alu_out    = w[ALU_LSB   +: DATA_W];
    p.write_data = w[WDATA_LSB +: DATA_W];
    p.pc_branch  = w[PCB_LSB   +: DATA_W];
    p.pc_plus4   = w[PC4_LSB   +: DATA_W];
    p.write_reg  = w[WREG_LSB  +: REG_W];
    p.zero       = w[ZERO_LSB];
    return p;
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// One elastic skid-buffer stage: main + skid register, registered ready.
// The low CLR_W bits of the word are control and are cleared on flush.
module pipe_skid_stage #(
  parameter int W     = 8,
  parameter int CLR_W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_bits,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_bits
);

  logic         m_v_q, m_v_d, s_v_q, s_v_d;
  logic [W-1:0] m_bits_q, m_bits_d, s_bits_q, s_bits_d;
  logic         accept, pop;

  assign in_ready  = !s_v_q;
  assign out_valid = m_v_q;
  assign out_bits  = m_bits_q;
  assign accept    = in_valid & !s_v_q;
  assign pop       = m_v_q & out_ready;

  // Next state: main refills from skid first, else from input; skid only
  // catches an accepted word when main is held by downstream.
  always_comb begin
    m_v_d    = m_v_q;
    s_v_d    = s_v_q;
    m_bits_d = m_bits_q;
    s_bits_d = s_bits_q;
    if (flush) begin
      m_v_d = 1'b0;
      s_v_d = 1'b0;
      m_bits_d[CLR_W-1:0] = '0;
      s_bits_d[CLR_W-1:0] = '0;
    end else if (!m_v_q || pop) begin
      if (s_v_q) begin
        m_v_d    = 1'b1;
        m_bits_d = s_bits_q;
        s_v_d    = 1'b0;
      end else begin
        m_v_d = accept;
        if (accept) m_bits_d = in_bits;
      end
    end else if (accept) begin
      s_v_d    = 1'b1;
      s_bits_d = in_bits;
    end
  end

  // State registers, async reset to empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v_q    <= 1'b0;
      s_v_q    <= 1'b0;
      m_bits_q <= '0;
      s_bits_q <= '0;
    end else begin
      m_v_q    <= m_v_d;
      s_v_q    <= s_v_d;
      m_bits_q <= m_bits_d;
      s_bits_q <= s_bits_d;
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// Elastic EX->MEM pipeline register: STAGES chained skid stages, occupancy
// counter, synchronous flush and bubble gating of control bits.
module ex_mem_pipe #(
  parameter int CTRL_W    = ex_mem_pkg::CTRL_W,
  parameter int DATA_W    = ex_mem_pkg::DATA_W,
  parameter int REG_W     = ex_mem_pkg::REG_W,
  parameter int STAGES    = 1,
  parameter int PAYLOAD_W = 4*DATA_W + REG_W + 1,
  localparam int OCC_W    = $clog2(2*STAGES+1)
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [OCC_W-1:0]     occupancy
);

  localparam int W = CTRL_W + PAYLOAD_W;

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("ex_mem_pipe: STAGES must be in 1..4");
  end

  // Chain buses: index i feeds stage i, index i+1 is its output
  logic [STAGES:0]        vld;
  logic [STAGES:0]        rdy;
  logic [STAGES:0][W-1:0] bus;

  assign vld[0]      = in_valid;
  assign bus[0]      = {in_data, in_ctrl};
  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    pipe_skid_stage #(.W(W), .CLR_W(CTRL_W)) u_stage (
      .clk       (CLOCK),
      .rst       (RESET),
      .flush     (flush),
      .in_valid  (vld[i]),
      .in_ready  (rdy[i]),
      .in_bits   (bus[i]),
      .out_valid (vld[i+1]),
      .out_ready (rdy[i+1]),
      .out_bits  (bus[i+1])
    );
  end

  assign out_valid = vld[STAGES];
  assign out_data  = bus[STAGES][W-1:CTRL_W];
  assign out_ctrl  = bus[STAGES][CTRL_W-1:0] & {CTRL_W{vld[STAGES]}};

  logic             in_fire, out_fire;
  logic [OCC_W-1:0] occ_q, occ_d;

  assign in_fire   = in_valid & rdy[0];
  assign out_fire  = vld[STAGES] & out_ready;
  assign occupancy = occ_q;

  // Occupancy next value: flush empties everything, else +accept -deliver
  always_comb begin
    occ_d = occ_q;
    if (flush) occ_d = '0;
    else if (in_fire && !out_fire) occ_d = occ_q + OCC_W'(1);
    else if (!in_fire && out_fire) occ_d = occ_q - OCC_W'(1);
  end

  // Occupancy register
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) occ_q <= '0;
    else       occ_q <= occ_d;
  end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed self-checking bench for ex_mem_pipe with STAGES=2.
module tb_ex_mem_pipe;
  import ex_mem_pkg::*;

  localparam int ST    = 2;
  localparam int OCC_W = $clog2(2*ST+1);

  logic                 CLOCK, RESET, flush;
  logic                 in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0]    in_ctrl, out_ctrl;
  logic [PAYLOAD_W-1:0] in_data, out_data;
  logic [OCC_W-1:0]     occupancy;

  int pass_cnt = 0;
  int total_cnt = 0;

  ex_mem_pipe #(.STAGES(ST)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  function automatic logic [PAYLOAD_W-1:0] mk(input logic [31:0] v);
    ex_mem_payload_t p;
    p.alu_out    = v;
    p.write_data = v ^ 32'hFFFF_0000;
    p.pc_branch  = v + 32'h100;
    p.pc_plus4   = v + 32'h4;
    p.write_reg  = v[4:0];
    p.zero       = (v == 32'h0);
    return pack_payload(p);
  endfunction

  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset;
    RESET = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if ({out_valid, out_ctrl, occupancy, in_ready, out_data} !== {1'b0, 4'b0, 3'd0, 1'b1, {PAYLOAD_W{1'b0}}})
      $display("FAIL reset_hold: v=%b ctrl=%b occ=%0d rdy=%b data=%h want 0/0/0/1/0",
               out_valid, out_ctrl, occupancy, in_ready, out_data);
    else pass_cnt++;
    RESET = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      total_cnt++;
      if ({out_valid, out_ctrl, occupancy, in_ready} !== {1'b0, 4'b0, 3'd0, 1'b1})
        $display("FAIL idle_c%0d: v=%b ctrl=%b occ=%0d rdy=%b want 0/0000/0/1",
                 c, out_valid, out_ctrl, occupancy, in_ready);
      else pass_cnt++;
    end
  endtask

  task automatic test_stream;
    int k;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        in_valid = 1'b1; in_ctrl = 4'b0001; in_data = mk(32'h10 * (i + 1));
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL stream_rdy_%0d: got %b want 1", i, in_ready);
        else pass_cnt++;
      end else in_valid = 1'b0;
      tick();
      k = i - 1;
      total_cnt++;
      if (k >= 0 && k < 4) begin
        if (out_valid !== 1'b1 || out_data[PAYLOAD_W-1 -: 32] !== 32'h10 * (k + 1) ||
            out_data !== mk(32'h10 * (k + 1)) || out_ctrl !== 4'b0001)
          $display("FAIL stream_out_%0d: v=%b alu=%h ctrl=%b want 1/%h/0001",
                   i, out_valid, out_data[PAYLOAD_W-1 -: 32], out_ctrl, 32'h10 * (k + 1));
        else pass_cnt++;
      end else begin
        if (out_valid !== 1'b0 || out_ctrl !== 4'b0)
          $display("FAIL stream_idle_%0d: v=%b ctrl=%b want 0/0000", i, out_valid, out_ctrl);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_backpressure;
    int nxt = 1;
    logic acc;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_ctrl = 4'b0011; in_data = mk(nxt);
      acc = in_ready;
      tick();
      if (acc) nxt++;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (nxt - 1 !== 4 || in_ready !== 1'b0 || occupancy !== 3'd4 || out_valid !== 1'b1)
      $display("FAIL bp_fill: acc=%0d rdy=%b occ=%0d v=%b want 4/0/4/1", nxt - 1, in_ready, occupancy, out_valid);
    else pass_cnt++;
    out_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== mk(j))
        $display("FAIL bp_drain_%0d: v=%b alu=%h want 1/%h", j, out_valid, out_data[PAYLOAD_W-1 -: 32], j);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0 || in_ready !== 1'b1)
      $display("FAIL bp_empty: v=%b occ=%0d rdy=%b want 0/0/1", out_valid, occupancy, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_ctrl = 4'b0101; in_data = mk(32'h51 + i);
      tick();
    end
    total_cnt++;
    if (occupancy !== 3'd3 || out_valid !== 1'b1 || out_ctrl !== 4'b0101)
      $display("FAIL flush_pre: occ=%0d v=%b ctrl=%b want 3/1/0101", occupancy, out_valid, out_ctrl);
    else pass_cnt++;
    flush = 1'b1; in_valid = 1'b1; in_data = mk(32'h99); out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || out_ctrl !== 4'b0 || occupancy !== 3'd0 || in_ready !== 1'b1)
      $display("FAIL flush_after: v=%b ctrl=%b occ=%0d rdy=%b want 0/0000/0/1",
               out_valid, out_ctrl, occupancy, in_ready);
    else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      tick();
      total_cnt++;
      if (out_valid !== 1'b0 || out_ctrl !== 4'b0)
        $display("FAIL flush_leak_%0d: v=%b ctrl=%b want 0/0000", c, out_valid, out_ctrl);
      else pass_cnt++;
    end
  endtask

  task automatic test_gating;
    logic [3:0] exp_ctrl;
    out_ready = 1'b1;
    in_valid = 1'b1; in_ctrl = 4'b1111; in_data = mk(32'h77);
    tick();
    in_valid = 1'b0; in_ctrl = 4'b0;
    for (int c = 1; c <= 5; c++) begin
      exp_ctrl = (c == 2) ? 4'b1111 : 4'b0000;
      total_cnt++;
      if (out_ctrl !== exp_ctrl || out_valid !== (c == 2))
        $display("FAIL gate_c%0d: ctrl=%b v=%b want %b/%b", c, out_ctrl, out_valid, exp_ctrl, (c == 2));
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_ctrl = 4'b0001; in_data = mk(32'hC0 + i);
      tick();
    end
    in_valid = 1'b0;
    total_cnt++;
    if (occupancy !== 3'd3 || out_valid !== 1'b1)
      $display("FAIL arst_pre: occ=%0d v=%b want 3/1", occupancy, out_valid);
    else pass_cnt++;
    #2 RESET = 1'b1;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0 || out_ctrl !== 4'b0 || in_ready !== 1'b1 || out_data !== '0)
      $display("FAIL arst_async: v=%b occ=%0d ctrl=%b rdy=%b want 0/0/0000/1", out_valid, occupancy, out_ctrl, in_ready);
    else pass_cnt++;
    tick();
    RESET = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 4'b0011; in_data = mk(32'hAA);
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || occupancy !== 3'd1)
      $display("FAIL arst_lat1: v=%b occ=%0d want 0/1", out_valid, occupancy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== mk(32'hAA) || out_ctrl !== 4'b0011)
      $display("FAIL arst_out: v=%b alu=%h ctrl=%b want 1/aa/0011", out_valid, out_data[PAYLOAD_W-1 -: 32], out_ctrl);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0)
      $display("FAIL arst_done: v=%b occ=%0d want 0/0", out_valid, occupancy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_gating();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
